// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD pixel pipeline: display geometry defaults,
// fetch FSM state encoding and RGB565 -> RGB888 colour expansion.
package lcd_pkg;

  localparam int unsigned H_DISP_DEFAULT = 135;
  localparam int unsigned V_DISP_DEFAULT = 240;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

  // Replicate the top bits of each channel into the new LSBs so that full
  // scale maps to full scale and truncation gives back the original word.
  function automatic logic [23:0] rgb565_to_888(input logic [15:0] word);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = word[15:11];
    g6 = word[10:5];
    b5 = word[4:0];
    return {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Ping-pong line buffer: two banks of DEPTH 16-bit words, the bank is the
// address MSB. One write port, one registered read port; a read of the word
// being written in the same cycle returns the old contents.
module line_buf_ram #(
  parameter int unsigned DEPTH = 135,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW:0]   rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] mem [2][DEPTH];

  // Store incoming pixel words into the addressed bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[AW]][wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Registered read port feeding the pixel output stage.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr[AW]][rd_addr[AW-1:0]];
  end

endmodule

// File: rtl/lcd_line_fetch.sv
// Frame-buffer line fetcher: fills a two-bank line buffer from a memory read
// port one display line ahead of the LCD driver and serves RGB888 pixels for
// the driver's current position.
module lcd_line_fetch
  import lcd_pkg::*;
#(
  parameter int unsigned       H_DISP    = H_DISP_DEFAULT,
  parameter int unsigned       V_DISP    = V_DISP_DEFAULT,
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       pixel_hpos,
  input  logic [11:0]       pixel_vpos,
  output logic [23:0]       pixel_data,
  output logic              pixel_valid,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_rsp_valid,
  input  logic [15:0]       rd_rsp_data,
  output logic              underrun
);

  localparam int unsigned WA = $clog2(H_DISP);
  localparam int unsigned CW = $clog2(H_DISP + 1);
  localparam int unsigned LW = $clog2(V_DISP);

  localparam logic [CW-1:0]     H_LAST     = CW'(H_DISP - 1);
  localparam logic [CW-1:0]     H_CNT      = CW'(H_DISP);
  localparam logic [11:0]       H_DISP_12  = 12'(H_DISP);
  localparam logic [LW-1:0]     V_LAST     = LW'(V_DISP - 1);
  localparam logic [ADDR_W-1:0] PIX_BYTES  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(2 * H_DISP);

  fetch_state_t      state;
  logic [CW-1:0]     req_cnt;
  logic [CW-1:0]     rsp_cnt;
  logic [LW-1:0]     fetch_line;
  logic              fetch_bank;
  logic [ADDR_W-1:0] line_base;
  logic [LW-1:0]     bank_tag [2];
  logic [1:0]        bank_full;
  logic [11:0]       vpos_q;

  logic              start_fetch;
  logic              hit0;
  logic              hit1;
  logic              rd_hit;
  logic              rd_bank;
  logic              hpos_in_range;
  logic [WA-1:0]     rd_word;
  logic [15:0]       ram_rd_data;
  logic              show_q;

  // The fetch bank is reusable unless it already holds the line on screen.
  always_comb begin
    start_fetch = !bank_full[fetch_bank] || (12'(bank_tag[fetch_bank]) != vpos_q);
  end

  // Fetch FSM: claim a bank, stream line requests, wait for every response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH_IDLE;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      req_cnt      <= '0;
      rsp_cnt      <= '0;
      fetch_line   <= '0;
      fetch_bank   <= 1'b0;
      line_base    <= BASE_ADDR;
      bank_full    <= '0;
      bank_tag[0]  <= '0;
      bank_tag[1]  <= '0;
    end else begin
      if (rd_rsp_valid) begin
        rsp_cnt <= rsp_cnt + 1'b1;
      end
      unique case (state)
        FETCH_IDLE: begin
          if (start_fetch) begin
            bank_full[fetch_bank] <= 1'b0;
            bank_tag[fetch_bank]  <= fetch_line;
            req_cnt               <= '0;
            rsp_cnt               <= '0;
            rd_req_valid          <= 1'b1;
            rd_req_addr           <= line_base;
            state                 <= FETCH_REQ;
          end
        end
        FETCH_REQ: begin
          if (rd_req_ready) begin
            req_cnt <= req_cnt + 1'b1;
            if (req_cnt == H_LAST) begin
              rd_req_valid <= 1'b0;
              state        <= FETCH_DRAIN;
            end else begin
              rd_req_addr <= rd_req_addr + PIX_BYTES;
            end
          end
        end
        FETCH_DRAIN: begin
          if (rsp_cnt == H_CNT) begin
            bank_full[fetch_bank] <= 1'b1;
            if (fetch_line == V_LAST) begin
              fetch_line <= '0;
              line_base  <= BASE_ADDR;
            end else begin
              fetch_line <= fetch_line + 1'b1;
              line_base  <= line_base + LINE_BYTES;
            end
            fetch_bank <= ~fetch_bank;
            state      <= FETCH_IDLE;
          end
        end
        default: state <= FETCH_IDLE;
      endcase
    end
  end

  // Registered copy of the display line used to decide bank reuse.
  always_ff @(posedge clk) begin
    if (rst) begin
      vpos_q <= '0;
    end else begin
      vpos_q <= pixel_vpos;
    end
  end

  // Pick the filled bank tagged with the displayed line, if any.
  always_comb begin
    hit0          = bank_full[0] && (12'(bank_tag[0]) == pixel_vpos);
    hit1          = bank_full[1] && (12'(bank_tag[1]) == pixel_vpos);
    rd_hit        = hit0 || hit1;
    rd_bank       = !hit0;
    hpos_in_range = pixel_hpos < H_DISP_12;
    rd_word       = hpos_in_range ? pixel_hpos[WA-1:0] : '0;
  end

  line_buf_ram #(
    .DEPTH (H_DISP),
    .AW    (WA)
  ) u_line_buf_ram (
    .clk     (clk),
    .wr_en   (rd_rsp_valid),
    .wr_addr ({fetch_bank, rsp_cnt[WA-1:0]}),
    .wr_data (rd_rsp_data),
    .rd_addr ({rd_bank, rd_word}),
    .rd_data (ram_rd_data)
  );

  // Register hit status alongside the RAM read so data and valid line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_valid <= 1'b0;
      show_q      <= 1'b0;
    end else begin
      pixel_valid <= rd_hit;
      show_q      <= rd_hit && hpos_in_range;
    end
  end

  assign pixel_data = show_q ? rgb565_to_888(ram_rd_data) : 24'h0;

  // Sticky flag: the display moved onto a line that was not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if ((pixel_vpos != vpos_q) && !rd_hit) begin
      underrun <= 1'b1;
    end
  end

endmodule
